fnd_scan_ctrl: RTL and testbench



---
 rtl/fnd_pkg.sv | 32 +++
 rtl/fnd_font_decoder.sv | 37 +++
 rtl/fnd_scan_ctrl.sv | 101 ++++++++++
 tb/tb_fnd_scan_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared definitions for the 4-digit common-anode FND scan driver.
//   state_e    : scan FSM states (DEAD = all commons off, SHOW = one digit lit)
//   FONT_*     : active-low {dp,g,f,e,d,c,b,a} codes with the decimal point off
//   COM_OFF    : all digit commons released (active-low)
//   com_on()   : active-low common pattern that lights a single digit position
package fnd_pkg;

  typedef enum logic {
    DEAD = 1'b0,
    SHOW = 1'b1
  } state_e;

  localparam logic [7:0] FONT_0     = 8'hC0;
  localparam logic [7:0] FONT_1     = 8'hF9;
  localparam logic [7:0] FONT_2     = 8'hA4;
  localparam logic [7:0] FONT_3     = 8'hB0;
  localparam logic [7:0] FONT_4     = 8'h99;
  localparam logic [7:0] FONT_5     = 8'h92;
  localparam logic [7:0] FONT_6     = 8'h82;
  localparam logic [7:0] FONT_7     = 8'hF8;
  localparam logic [7:0] FONT_8     = 8'h80;
  localparam logic [7:0] FONT_9     = 8'h90;
  localparam logic [7:0] FONT_DASH  = 8'hBF;
  localparam logic [7:0] FONT_BLANK = 8'hFF;

  localparam logic [3:0] COM_OFF = 4'b1111;

  function automatic logic [3:0] com_on(input logic [1:0] pos);
    return ~(4'b0001 << pos);
  endfunction

endpackage

// File: rtl/fnd_font_decoder.sv
// Combinational 7-segment font decoder.
//   i_value : 4-bit digit code; 0-9 digits, A-E dash, F blank
//   i_dp    : 1 = light the decimal point
//   o_font  : active-low {dp,g,f,e,d,c,b,a}
// The decimal point is independent of the value, so a blank digit can
// still show its dot.
module fnd_font_decoder
  import fnd_pkg::*;
(
  input  logic [3:0] i_value,
  input  logic       i_dp,
  output logic [7:0] o_font
);

  logic [7:0] seg;

  always_comb begin
    seg = FONT_BLANK;
    case (i_value)
      4'h0:    seg = FONT_0;
      4'h1:    seg = FONT_1;
      4'h2:    seg = FONT_2;
      4'h3:    seg = FONT_3;
      4'h4:    seg = FONT_4;
      4'h5:    seg = FONT_5;
      4'h6:    seg = FONT_6;
      4'h7:    seg = FONT_7;
      4'h8:    seg = FONT_8;
      4'h9:    seg = FONT_9;
      4'hA, 4'hB, 4'hC, 4'hD, 4'hE:
               seg = FONT_DASH;
      default: seg = FONT_BLANK;
    endcase
    o_font = {~i_dp, seg[6:0]};
  end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Time-multiplexed scan driver for a 4-digit common-anode FND.
//   i_clk, i_reset     : clock, synchronous active-high reset
//   i_enable           : 1 = scan, 0 = blank (position held)
//   i_value            : digit value selected by o_digitPosition (external mux)
//   i_dpMask           : per-position decimal point enable
//   o_digitPosition    : digit select to the mux (0 = ones .. 3 = thousands)
//   o_fndCom           : active-low digit commons
//   o_fndFont          : active-low {dp,g,f,e,d,c,b,a}
// Each slot is DEAD_CYCLES with all commons off followed by SHOW_CYCLES with
// one digit lit. The position only advances as a digit turns off, so the
// mux and font register settle during the dead interval.
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int unsigned SHOW_CYCLES = 100_000,
  parameter int unsigned DEAD_CYCLES = 1_000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic [3:0] i_value,
  input  logic [3:0] i_dpMask,
  output logic [1:0] o_digitPosition,
  output logic [3:0] o_fndCom,
  output logic [7:0] o_fndFont
);

  localparam int unsigned MAX_CYCLES = (SHOW_CYCLES > DEAD_CYCLES) ? SHOW_CYCLES : DEAD_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES);
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [1:0]       pos_q,   pos_d;
  logic [3:0]       com_q,   com_d;
  logic [7:0]       font_q,  font_d;

  fnd_font_decoder u_font (
    .i_value (i_value),
    .i_dp    (i_dpMask[pos_q]),
    .o_font  (font_d)
  );

  // Commons are computed from the next state so the registered output
  // lines up exactly with the state it belongs to.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    pos_d   = pos_q;
    com_d   = COM_OFF;
    if (!i_enable) begin
      state_d = DEAD;
      cnt_d   = '0;
    end else begin
      case (state_q)
        DEAD: begin
          if (cnt_q == DEAD_LAST) begin
            state_d = SHOW;
            cnt_d   = '0;
            com_d   = com_on(pos_q);
          end
        end
        SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_d = DEAD;
            cnt_d   = '0;
            pos_d   = pos_q + 2'd1;
          end else begin
            com_d   = com_on(pos_q);
          end
        end
        default: begin
          state_d = DEAD;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= DEAD;
      cnt_q   <= '0;
      pos_q   <= 2'd0;
      com_q   <= COM_OFF;
      font_q  <= FONT_BLANK;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      com_q   <= com_d;
      font_q  <= font_d;
    end
  end

  assign o_digitPosition = pos_q;
  assign o_fndCom        = com_q;
  assign o_fndFont       = font_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Self-checking bench for fnd_scan_ctrl (SHOW_CYCLES = 4, DEAD_CYCLES = 2).
// A slot-arithmetic reference model produces the expected outputs after
// every clock edge; they go through a scoreboard queue and are compared
// one time unit after the edge.
module tb_fnd_scan_ctrl;

  localparam int SHOW = 4;
  localparam int DEAD = 2;
  localparam int SLOT = SHOW + DEAD;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [3:0] i_value, dp_mask;
  logic [1:0] o_pos;
  logic [3:0] o_com;
  logic [7:0] o_font;

  logic       mux_mode;
  logic [3:0] val_reg;
  logic [3:0] digs [4];

  always #5 clk = ~clk;

  // Digit mux: position-dependent digits 4,3,2,1 for positions 0..3.
  always_comb i_value = mux_mode ? digs[o_pos] : val_reg;

  fnd_scan_ctrl #(.SHOW_CYCLES(SHOW), .DEAD_CYCLES(DEAD)) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_enable        (en),
    .i_value         (i_value),
    .i_dpMask        (dp_mask),
    .o_digitPosition (o_pos),
    .o_fndCom        (o_com),
    .o_fndFont       (o_font)
  );

  typedef struct packed {
    logic [3:0] com;
    logic [7:0] font;
    logic [1:0] pos;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  int         m_k    = 0;
  int         m_base = 0;
  logic [1:0] m_pos  = 2'd0;
  logic       m_lit  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_font(input logic [3:0] v, input logic dp);
    logic [7:0] f;
    case (v)
      4'h0: f = 8'hC0;
      4'h1: f = 8'hF9;
      4'h2: f = 8'hA4;
      4'h3: f = 8'hB0;
      4'h4: f = 8'h99;
      4'h5: f = 8'h92;
      4'h6: f = 8'h82;
      4'h7: f = 8'hF8;
      4'h8: f = 8'h80;
      4'h9: f = 8'h90;
      4'hF: f = 8'hFF;
      default: f = 8'hBF;
    endcase
    f[7] = ~dp;
    return f;
  endfunction

  // k = edges since the scan (re)started; lit once the first dead interval is over.
  function automatic logic lit_at(input int k);
    return (k >= DEAD) && (((k - DEAD) % SLOT) < SHOW);
  endfunction

  // One clock edge: snapshot inputs, advance the model, push expectation,
  // then pop and compare just after the edge.
  task automatic step();
    logic       r, e;
    logic [3:0] d, v;
    logic [1:0] pre_pos;
    exp_t       x, got;
    r = rst; e = en; d = dp_mask;
    v = mux_mode ? digs[m_pos] : val_reg;
    pre_pos = m_pos;
    @(posedge clk);
    x.font = r ? 8'hFF : ref_font(v, d[pre_pos]);
    if (r) begin
      m_k = 0; m_base = 0;
    end else if (!e) begin
      m_k = 0; m_base = int'(pre_pos);
    end else begin
      m_k++;
    end
    m_pos = 2'((m_base + m_k / SLOT) % 4);
    m_lit = !r && e && lit_at(m_k);
    x.com = m_lit ? ~(4'b0001 << m_pos) : 4'b1111;
    x.pos = m_pos;
    sb_q.push_back(x);
    #1;
    got = sb_q.pop_front();
    check("com",  {28'd0, o_com},  {28'd0, got.com});
    check("font", {24'd0, o_font}, {24'd0, got.font});
    check("pos",  {30'd0, o_pos},  {30'd0, got.pos});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance until the model shows a lit digit at position p (p < 0: any).
  task automatic run_until_lit(input int p);
    bit hit;
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      step();
      if (m_lit && (p < 0 || int'(m_pos) == p)) hit = 1;
    end
    check("wait_lit_timeout", {31'd0, hit}, 32'd1);
  endtask

  initial begin
    digs[0] = 4'h4; digs[1] = 4'h3; digs[2] = 4'h2; digs[3] = 4'h1;
    mux_mode = 1'b0; val_reg = 4'h0; dp_mask = 4'b0000;
    rst = 1'b1; en = 1'b1;

    // Reset (with enable high) and basic timing: 2 dead, 4 lit, 2 dead, next digit.
    run(2);
    check("rst_com",  {28'd0, o_com},  32'hF);
    check("rst_font", {24'd0, o_font}, 32'hFF);
    check("rst_pos",  {30'd0, o_pos},  32'd0);
    rst = 1'b0;
    run(14);

    // Position-dependent digits, two full frames including the 3 -> 0 wrap.
    mux_mode = 1'b1;
    run(4 * SLOT * 2);

    // Blank value with decimal point on digit 1 only.
    mux_mode = 1'b0; val_reg = 4'hF; dp_mask = 4'b0010;
    run(4 * SLOT + 2);

    // Enable dropped mid-SHOW at position 2, then restored.
    mux_mode = 1'b1; dp_mask = 4'b0000;
    run_until_lit(2);
    en = 1'b0;
    run(3);
    check("dis_com", {28'd0, o_com}, 32'hF);
    check("dis_pos", {30'd0, o_pos}, 32'd2);
    en = 1'b1;
    run(DEAD);
    check("reen_com", {28'd0, o_com}, 32'hB);
    run(6);

    // Reset pulsed mid-SHOW at position 3.
    run_until_lit(3);
    rst = 1'b1;
    step();
    check("midrst_font", {24'd0, o_font}, 32'hFF);
    rst = 1'b0;
    run(14);

    // Live font update during a lit slot: 7 -> A.
    mux_mode = 1'b0; val_reg = 4'h7;
    run_until_lit(-1);
    run(0);
    check("live_before", {24'd0, o_font}, 32'hF8);
    val_reg = 4'hA;
    step();
    check("live_after", {24'd0, o_font}, 32'hBF);
    run(SLOT);

    // Reset and enable high together: reset wins.
    rst = 1'b1; en = 1'b1;
    step();
    rst = 1'b0;
    run(SLOT + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
